seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Multiplexed N-digit seven-segment display driver for the board's common-anode display bank: it time-scans DIGITS digits, decodes each 4-bit nibble to an active-low segment pattern, and drives one anode at a time. Display contents are double-buffered behind a load handshake so that updates commit only at frame boundaries, never mid-scan. It is the sequential successor to the team's single-digit hex decoder. It adds per-digit enable, decimal points, leading-zero suppression and anti-ghost blanking.

## Interface
- DIGITS, 8: number of digits scanned (1..8)
- DIV, 100000: clk cycles per digit slot (≥ BLANK+1)
- BLANK, 4: cycles at the start of each slot with all anodes off (anti-ghost, ≥ 0)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- data  in  4*DIGITS  nibble for digit i at data[4i+3:4i]
- dp  in  DIGITS  decimal point request per digit (1 = lit)
- en  in  DIGITS  digit enable mask (0 = digit blank)
- lz_blank  in  1  leading-zero suppression mode
- load  in  1  one-cycle request to capture data/dp/en/lz_blank
- busy  out  1  captured update pending, not yet displayed
- frame  out  1  one-cycle pulse after scan wraps to digit 0
- AN  out  DIGITS  anode selects, active-low, AN[i] = digit i
- SEG  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

## Operation
- Two register sets, each holding {data, dp, en, lz_blank}:
  - pending: written by load.
  - active: drives the display.
- load: pending ← inputs; busy ← 1. Loads while busy overwrite pending, so the latest load wins.
- Commit on the wrap cycle (tick with idx = DIGITS-1), if busy: active ← pending; busy ← 0.
- Load on the wrap cycle: the old pending commits, the new data is captured into pending, and busy stays 1. The new data commits at the next wrap.
- Slot counter cnt runs 0..DIV-1. tick = (cnt = DIV-1). On tick: cnt ← 0, idx ← idx+1, wrapping DIGITS-1 → 0.
- Digit visible in a cycle iff all of the following hold:
  - cnt ≥ BLANK
  - en[idx] = 1
  - the digit is not suppressed
- Visible digit: AN = ~(1<<idx); SEG[6:0] = code(nibble); SEG[7] = ~dp[idx].
- Not visible: AN = all ones; SEG = 8'hFF.
- Leading-zero suppression (active lz_blank = 1): scanning from digit DIGITS-1 downward, each digit with nibble 0 and dp 0 is suppressed until the first digit failing that test. Digit 0 is never suppressed.
- Hex codes (SEG with dp off), 0..F:
  - 0–7: C0 F9 A4 B0 99 92 82 F8
  - 8–F: 80 98 88 83 C6 A1 86 8E

## Timing
- Reset values:
  - AN = all ones; SEG = 8'hFF; busy = 0; frame = 0
  - cnt = 0; idx = 0
  - pending and active cleared (en = 0, so the display stays dark until the first commit)
- AN/SEG are registered from the current (idx, cnt, active) and lag those by 1 cycle.
- frame is registered from wrap. It is high in the cycle after wrap, in which AN/SEG still show the last cycle of digit DIGITS-1 and the newly committed data is first used internally.
- Latency from load to first visible new segment: up to DIGITS*DIV + BLANK + 2 cycles.
- busy falls in the cycle after the commit edge, coincident with frame.
- rst mid-scan: all registers return to reset values on the next edge. Pending data is discarded and busy = 0.
- DIGITS = 1: idx stays 0, and every tick is a wrap.

## Structure
- Shared package seg_pkg:
  - SEG_OFF = 8'hFF
  - 16-entry hex code table constant
  - segment bit-position constants
- Sub-module seg_hex_decode: combinational nibble + dp → 8-bit active-low SEG. It is instantiated once, on the muxed nibble.
- Top level holds the slot counter, index counter, pending/active registers, suppression logic and output registers.

## Test plan
All scenarios use DIGITS=4, DIV=8, BLANK=2.
- Reset: hold rst 3 cycles → AN=4'hF, SEG=8'hFF, busy=0, frame=0. With no load, AN stays 4'hF for 3 frames.
- Basic scan: load data=16'h1234, en=4'hF, dp=0. Expect:
  - busy=1 until the first frame pulse.
  - Then each 8-cycle slot shows 2 cycles AN=F followed by 6 cycles of the digit: AN=E/SEG=99, AN=D/SEG=B0, AN=B/SEG=A4, AN=7/SEG=F9.
- Decode/dp sweep: digit 0 nibble 0..F with dp[0]=1 → SEG = table value with bit 7 cleared (e.g. nibble 4 → 8'h19).
- Leading zeros: lz_blank=1, data=16'h0050, dp=0. Expect:
  - Digits 3 and 2 dark (AN=F); digit 1 SEG=92; digit 0 SEG=C0.
  - data=16'h0000 → only digit 0 lit, SEG=C0.
  - dp[2]=1 → digit 2 shows C0 with bit 7 = 0 (8'h40).
- Handshake: load 16'h1111, then 16'h2222 before the frame boundary → only 2222 (SEG=A4) is ever displayed. Load on the wrap cycle → old pending displays for one frame, busy stays 1, new data appears the frame after.
- Mask and reset: en=4'b0101 → AN never equals D or 7. Assert rst mid-slot with busy=1 → next cycle AN=F, SEG=FF, busy=0, and the old data does not reappear.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern, segment
// bit positions and the active-low hex glyph table.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte
   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry n lives at [8n+7:8n]; all glyphs have the dp bit off (1)
   localparam logic [127:0] HEX_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] hex_code(input logic [3:0] nib);
      return HEX_TABLE[{nib, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to active-low segment byte.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   logic [7:0] code;

   always_comb begin
      code                 = hex_code(nib_i);
      seg_o                = SEG_OFF;
      seg_o[SEG_G:SEG_A]   = code[SEG_G:SEG_A];
      seg_o[SEG_DP]        = ~dp_i;
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode display driver: slot/digit scan, double-buffered
// contents committed at frame wrap, leading-zero suppression and blanking.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int DIV    = 100000,
   parameter int BLANK  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     en,
   input  logic                  lz_blank,
   input  logic                  load,
   output logic                  busy,
   output logic                  frame,
   output logic [DIGITS-1:0]     AN,
   output logic [7:0]            SEG
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   pend_data_q, act_data_q;
   logic [DIGITS-1:0]     pend_dp_q, act_dp_q;
   logic [DIGITS-1:0]     pend_en_q, act_en_q;
   logic                  pend_lz_q, act_lz_q;
   logic                  busy_q, frame_q;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [7:0]            seg_q, seg_d;

   logic                  tick, wrap;
   logic [DIGITS-1:0]     supp;
   logic                  lead;
   logic [3:0]            nib;
   logic                  vis;
   logic [7:0]            dec_seg;

   assign tick = (cnt_q == CNT_MAX);
   assign wrap = tick && (idx_q == IDX_MAX);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
   end

   // Suppress zero digits from the top down until the first significant one
   always_comb begin
      supp = '0;
      lead = act_lz_q;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (lead && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i]) supp[i] = 1'b1;
         else                                                        lead    = 1'b0;
      end
   end

   assign nib = act_data_q[{idx_q, 2'b00} +: 4];
   assign vis = (cnt_q >= CNT_BLANK) && act_en_q[idx_q] && !supp[idx_q];

   seg_hex_decode u_dec (
      .nib_i (nib),
      .dp_i  (act_dp_q[idx_q]),
      .seg_o (dec_seg)
   );

   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      if (vis) begin
         an_d  = ~(DIGITS'(1) << idx_q);
         seg_d = dec_seg;
      end
   end

   // A load on the wrap edge commits the old pending set and keeps busy high
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_en_q   <= '0;
         pend_lz_q   <= 1'b0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         act_en_q    <= '0;
         act_lz_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_q     <= 1'b0;
         an_q        <= '1;
         seg_q       <= SEG_OFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frame_q <= wrap;
         an_q    <= an_d;
         seg_q   <= seg_d;
         if (wrap && busy_q) begin
            act_data_q <= pend_data_q;
            act_dp_q   <= pend_dp_q;
            act_en_q   <= pend_en_q;
            act_lz_q   <= pend_lz_q;
         end
         if (load) begin
            pend_data_q <= data;
            pend_dp_q   <= dp;
            pend_en_q   <= en;
            pend_lz_q   <= lz_blank;
            busy_q      <= 1'b1;
         end else if (wrap) begin
            busy_q      <= 1'b0;
         end
      end
   end

   assign busy  = busy_q;
   assign frame = frame_q;
   assign AN    = an_q;
   assign SEG   = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: time-indexed reference model feeds an expected
// queue each clock; a negedge monitor pops and compares every output.
module tb_seg_scan_driver;

   localparam int DIGITS = 4;
   localparam int DIV    = 8;
   localparam int BLANK  = 2;
   localparam int FRAME  = DIGITS * DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data;
   logic [3:0]  dp, en;
   logic        lz_blank, load;
   logic        busy, frame;
   logic [3:0]  AN;
   logic [7:0]  SEG;

   always #5 clk = ~clk;

   seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
      .clk(clk), .rst(rst), .data(data), .dp(dp), .en(en),
      .lz_blank(lz_blank), .load(load), .busy(busy), .frame(frame),
      .AN(AN), .SEG(SEG)
   );

   logic [7:0] hex_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference state: t counts cycles since reset released
   int          t;
   logic [15:0] p_data, a_data;
   logic [3:0]  p_dp, p_en, a_dp, a_en;
   logic        p_lz, a_lz, m_busy;
   logic [11:0] m_disp;
   logic        m_wrap;
   logic [13:0] exp_q[$];
   logic [13:0] e;
   int          total = 0;
   int          bad   = 0;

   // Expected {AN,SEG} for digit idx at slot offset cnt using the active set
   function automatic logic [11:0] expect_disp(int idx, int cnt);
      logic       supp;
      logic [3:0] an;
      logic [7:0] seg;
      supp = a_lz && (idx != 0);
      for (int j = DIGITS - 1; j >= idx; j--)
         if (a_data[4*j +: 4] != 4'h0 || a_dp[j]) supp = 1'b0;
      if (cnt < BLANK || !a_en[idx] || supp) return {4'hF, 8'hFF};
      seg      = hex_tab[a_data[4*idx +: 4]];
      seg[7]   = ~a_dp[idx];
      an       = 4'hF;
      an[idx]  = 1'b0;
      return {an, seg};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         p_data = '0; p_dp = '0; p_en = '0; p_lz = 1'b0;
         a_data = '0; a_dp = '0; a_en = '0; a_lz = 1'b0;
         m_busy = 1'b0;
         exp_q.push_back({1'b0, 1'b0, 4'hF, 8'hFF});
      end else begin
         m_disp = expect_disp((t / DIV) % DIGITS, t % DIV);
         m_wrap = ((t % FRAME) == FRAME - 1);
         if (m_wrap && m_busy) begin
            a_data = p_data; a_dp = p_dp; a_en = p_en; a_lz = p_lz;
            m_busy = 1'b0;
         end
         if (load) begin
            p_data = data; p_dp = dp; p_en = en; p_lz = lz_blank;
            m_busy = 1'b1;
         end
         exp_q.push_back({m_busy, m_wrap, m_disp});
         t++;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("busy",  {7'b0, busy},  {7'b0, e[13]});
         check("frame", {7'b0, frame}, {7'b0, e[12]});
         check("AN",    {4'b0, AN},    {4'b0, e[11:8]});
         check("SEG",   SEG,           e[7:0]);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                          input logic [3:0] m, input logic lz);
      data = d; dp = p; en = m; lz_blank = lz; load = 1'b1;
      step(1);
      load     = 1'b0;
      data     = 16'($urandom);
      dp       = 4'($urandom);
      en       = 4'($urandom);
      lz_blank = 1'($urandom);
   endtask

   // Advance until the next clock edge is the frame wrap
   task automatic wait_wrap();
      int k = 0;
      while ((t % FRAME) != FRAME - 1 && k < 2 * FRAME) begin
         step(1);
         k++;
      end
      if (k >= 2 * FRAME) begin
         total++;
         bad++;
         $display("FAIL wait_wrap: waited %0d cycles, limit %0d", k, 2 * FRAME);
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; data = '0; dp = '0; en = '0; lz_blank = 1'b0;
      step(3);
      rst = 1'b0;
      step(3 * FRAME);

      do_load(16'h1234, 4'h0, 4'hF, 1'b0);
      step(2 * FRAME + 5);

      for (int n = 0; n < 16; n++) begin
         do_load(16'(n), 4'b0001, 4'b0001, 1'b0);
         step(2 * FRAME);
      end

      do_load(16'h0050, 4'h0, 4'hF, 1'b1);
      step(2 * FRAME);
      do_load(16'h0000, 4'h0, 4'hF, 1'b1);
      step(2 * FRAME);
      do_load(16'h0000, 4'b0100, 4'hF, 1'b1);
      step(2 * FRAME);

      wait_wrap();
      step(1);
      do_load(16'h1111, 4'h0, 4'hF, 1'b0);
      step(5);
      do_load(16'h2222, 4'h0, 4'hF, 1'b0);
      step(2 * FRAME);

      wait_wrap();
      step(1);
      do_load(16'h3333, 4'h0, 4'hF, 1'b0);
      wait_wrap();
      do_load(16'h4444, 4'h0, 4'hF, 1'b0);
      step(3 * FRAME);

      do_load(16'h5678, 4'h0, 4'b0101, 1'b0);
      step(2 * FRAME);

      wait_wrap();
      step(4);
      do_load(16'h9999, 4'hF, 4'hF, 1'b0);
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2 * FRAME);

      for (int i = 0; i < 25; i++) begin
         do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         step($urandom_range(1, 2 * FRAME));
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            step($urandom_range(1, 2));
            rst = 1'b0;
         end
      end
      step(FRAME);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
